udp_payload_aligner: RTL

- Parametrised successor to the fixed 32-byte, 42-byte-header parser.
- Strips a configurable-length header from an AXI-Stream packet and exposes the header to the filter stage. It also realigns the payload so that output byte 0 is the first payload byte.
- Supports full out_ready backpressure, drops packets on a filter verdict, and counts runts and protocol errors.
- Sits between the MAC RX stream and the downstream UDP payload consumers.

---
 rtl/udp_pkg.sv | 32 +++
 rtl/udp_payload_aligner_byte_realigner.sv | 64 ++++++
 rtl/udp_payload_aligner.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_pkg.sv
// Shared types and helpers for the UDP payload aligner.
// Provides the parse-state enum, a keep popcount and a keep contiguity check.
package udp_pkg;

  typedef enum logic [2:0] {
    HDR,
    DECIDE,
    STREAM,
    FLUSH,
    DISCARD
  } state_t;

  localparam int MAXB = 128;

  function automatic int unsigned popcnt(
    input logic [MAXB-1:0] v
  );
    int unsigned c;
    c = 0;
    for (int i = 0; i < MAXB; i++)
      c += {31'b0, v[i]};
    return c;
  endfunction

  // Non-empty and a run of ones from bit 0.
  function automatic logic keep_ok(
    input logic [MAXB-1:0] v
  );
    return v[0] && ((v & (v + 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/udp_payload_aligner_byte_realigner.sv
// Residue register plus combine/shift datapath for payload realignment.
// Ports: i_data/i_cnt incoming bytes, i_push/i_clr control, o_beat/o_total/o_res/o_rcnt.
module byte_realigner #(
  parameter  int DATA_BYTES = 32,
  localparam int KW = $clog2(DATA_BYTES + 1),
  localparam int TW = $clog2(2 * DATA_BYTES + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [8*DATA_BYTES-1:0] i_data,
  input  logic [KW-1:0]           i_cnt,
  input  logic                    i_push,
  input  logic                    i_clr,
  output logic [8*DATA_BYTES-1:0] o_beat,
  output logic [TW-1:0]           o_total,
  output logic [8*DATA_BYTES-1:0] o_res,
  output logic [KW-1:0]           o_rcnt
);

  localparam int DB = DATA_BYTES;

  logic [8*DB-1:0]  r_res;
  logic [KW-1:0]    r_rcnt;
  logic [8*DB-1:0]  w_din;
  logic [8*DB-1:0]  w_res;
  logic [KW-1:0]    w_rc;
  logic [16*DB-1:0] w_comb;

  // Bytes past the count are zeroed so they never leak into the residue.
  always_comb begin
    w_din = '0;
    for (int i = 0; i < DB; i++)
      if (i < int'(i_cnt))
        w_din[8*i +: 8] = i_data[8*i +: 8];
    w_res  = i_clr ? '0 : r_res;
    w_rc   = i_clr ? '0 : r_rcnt;
    w_comb = {{(8*DB){1'b0}}, w_res}
           | ({{(8*DB){1'b0}}, w_din} << (8 * w_rc));
  end

  assign o_total = TW'(w_rc) + TW'(i_cnt);
  assign o_beat  = w_comb[8*DB-1:0];
  assign o_res   = r_res;
  assign o_rcnt  = r_rcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res  <= '0;
      r_rcnt <= '0;
    end else if (i_push) begin
      if (o_total >= TW'(DB)) begin
        r_res  <= w_comb[16*DB-1:8*DB];
        r_rcnt <= KW'(o_total - TW'(DB));
      end else begin
        r_res  <= w_comb[8*DB-1:0];
        r_rcnt <= KW'(o_total);
      end
    end else if (i_clr) begin
      r_res  <= '0;
      r_rcnt <= '0;
    end
  end

endmodule

// File: rtl/udp_payload_aligner.sv
// Strips a HEADER_BYTES header from an AXI-Stream packet and realigns the payload.
// Ports: in_* stream in, out_* stream out, hdr_* filter side, ts_* latency, *_cnt stats.
module udp_payload_aligner
  import udp_pkg::*;
#(
  parameter int DATA_BYTES   = 32,
  parameter int HEADER_BYTES = 42,
  parameter int TS_WIDTH     = 32,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [8*DATA_BYTES-1:0]   in_data,
  input  logic [DATA_BYTES-1:0]     in_keep,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic [8*DATA_BYTES-1:0]   out_data,
  output logic [DATA_BYTES-1:0]     out_keep,
  output logic                      out_valid,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic [8*HEADER_BYTES-1:0] hdr_data,
  output logic                      hdr_valid,
  input  logic                      hdr_drop,
  output logic                      ts_valid,
  output logic [TS_WIDTH-1:0]       ts_value,
  output logic [CNT_WIDTH-1:0]      runt_cnt,
  output logic [CNT_WIDTH-1:0]      drop_cnt,
  output logic [CNT_WIDTH-1:0]      err_cnt
);

  localparam int DB = DATA_BYTES;
  localparam int HB = HEADER_BYTES;
  localparam int KW = $clog2(DB + 1);
  localparam int TW = $clog2(2 * DB + 1);
  localparam int HW = $clog2(HB + DB + 1);

  state_t               r_state, w_state_n;
  logic [HW-1:0]        r_hcnt, w_hcnt_n;
  logic                 r_hlast, w_hlast_n;
  logic [TS_WIDTH-1:0]  r_cyc, r_start, r_ts;
  logic                 r_ts_valid, r_hdr_valid;
  logic [8*DB-1:0]      r_out_data;
  logic [DB-1:0]        r_out_keep;
  logic                 r_out_last, r_out_valid;
  logic [8*HB-1:0]      r_hdr;
  logic [CNT_WIDTH-1:0] r_runt, r_drop, r_err;

  logic            w_slot, w_acc, w_err, w_hdr_done, w_last_hs;
  logic [KW-1:0]   w_n;
  logic [HW-1:0]   w_hb;
  logic            w_push, w_clr, w_ld, w_ld_last;
  logic [KW-1:0]   w_ld_cnt, w_ra_cnt;
  logic [DB-1:0]   w_ld_keep;
  logic [8*DB-1:0] w_ld_data, w_ra_data;
  logic            w_hv, w_runt, w_drop, w_errinc, w_start;
  logic [8*DB-1:0] w_ra_beat, w_ra_res;
  logic [TW-1:0]   w_ra_total;
  logic [KW-1:0]   w_ra_rcnt;

  byte_realigner #(.DATA_BYTES(DB)) u_realign (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_data  (w_ra_data),
    .i_cnt   (w_ra_cnt),
    .i_push  (w_push),
    .i_clr   (w_clr),
    .o_beat  (w_ra_beat),
    .o_total (w_ra_total),
    .o_res   (w_ra_res),
    .o_rcnt  (w_ra_rcnt)
  );

  assign w_slot     = !r_out_valid || out_ready;
  assign in_ready   = (r_state == HDR || r_state == STREAM
                      || r_state == DISCARD) && w_slot;
  assign w_acc      = in_valid && in_ready;
  assign w_n        = KW'(popcnt(MAXB'(in_keep)));
  assign w_err      = !keep_ok(MAXB'(in_keep))
                    || (!in_last && !(&in_keep));
  assign w_hb       = HW'(HB) - r_hcnt;
  assign w_hdr_done = (r_hcnt + HW'(w_n)) >= HW'(HB);
  assign w_last_hs  = r_out_valid && out_ready && r_out_last;

  always_comb begin
    w_state_n = r_state;
    w_hcnt_n  = r_hcnt;
    w_hlast_n = r_hlast;
    w_push    = 1'b0;
    w_clr     = 1'b0;
    w_ld      = 1'b0;
    w_ld_last = 1'b0;
    w_ld_cnt  = KW'(DB);
    w_ld_data = w_ra_beat;
    w_ra_data = in_data;
    w_ra_cnt  = w_n;
    w_hv      = 1'b0;
    w_runt    = 1'b0;
    w_drop    = 1'b0;
    w_errinc  = 1'b0;
    w_start   = 1'b0;
    unique case (r_state)
      HDR: if (w_acc) begin
        w_start  = (r_hcnt == '0);
        w_hcnt_n = '0;
        if (w_err) begin
          w_errinc  = 1'b1;
          w_state_n = in_last ? HDR : DISCARD;
        end else if (w_hdr_done) begin
          // Payload tail of the header beat seeds an empty residue.
          w_hv      = 1'b1;
          w_push    = 1'b1;
          w_clr     = 1'b1;
          w_ra_data = in_data >> (8 * w_hb);
          w_ra_cnt  = KW'(HW'(w_n) - w_hb);
          w_hlast_n = in_last;
          w_state_n = DECIDE;
        end else if (in_last) begin
          w_runt = 1'b1;
        end else begin
          w_hcnt_n = r_hcnt + HW'(w_n);
        end
      end
      DECIDE: begin
        if (hdr_drop) begin
          w_drop    = 1'b1;
          w_state_n = r_hlast ? HDR : DISCARD;
        end else if (!r_hlast) begin
          w_state_n = STREAM;
        end else if (w_ra_rcnt == '0) begin
          w_runt    = 1'b1;
          w_state_n = HDR;
        end else if (w_slot) begin
          w_ld      = 1'b1;
          w_ld_data = w_ra_res;
          w_ld_cnt  = w_ra_rcnt;
          w_ld_last = 1'b1;
          w_state_n = HDR;
        end else begin
          // Output still busy with the prior packet: park in FLUSH.
          w_state_n = FLUSH;
        end
      end
      STREAM: if (w_acc) begin
        if (w_err) begin
          w_errinc  = 1'b1;
          w_state_n = in_last ? HDR : DISCARD;
        end else begin
          w_push = 1'b1;
          w_ld   = 1'b1;
          if (in_last && w_ra_total <= TW'(DB)) begin
            w_ld_cnt  = KW'(w_ra_total);
            w_ld_last = 1'b1;
            w_state_n = HDR;
          end else if (in_last) begin
            w_state_n = FLUSH;
          end
        end
      end
      FLUSH: if (w_slot) begin
        w_ld      = 1'b1;
        w_ld_data = w_ra_res;
        w_ld_cnt  = w_ra_rcnt;
        w_ld_last = 1'b1;
        w_state_n = HDR;
      end
      DISCARD: if (w_acc) begin
        w_errinc = w_err;
        if (in_last)
          w_state_n = HDR;
      end
      default: w_state_n = HDR;
    endcase
  end

  always_comb begin
    w_ld_keep = '0;
    for (int i = 0; i < DB; i++)
      w_ld_keep[i] = (i < int'(w_ld_cnt));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= HDR;
      r_hcnt      <= '0;
      r_hlast     <= 1'b0;
      r_cyc       <= '0;
      r_start     <= '0;
      r_ts        <= '0;
      r_ts_valid  <= 1'b0;
      r_hdr_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_keep  <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
      r_hdr       <= '0;
      r_runt      <= '0;
      r_drop      <= '0;
      r_err       <= '0;
    end else begin
      r_state     <= w_state_n;
      r_hcnt      <= w_hcnt_n;
      r_hlast     <= w_hlast_n;
      r_cyc       <= r_cyc + 1'b1;
      r_hdr_valid <= w_hv;
      r_ts_valid  <= w_last_hs;
      if (w_start)
        r_start <= r_cyc;
      if (w_last_hs)
        r_ts <= r_cyc - r_start;
      if (w_ld) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_ld_data;
        r_out_keep  <= w_ld_keep;
        r_out_last  <= w_ld_last;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_runt && !(&r_runt))
        r_runt <= r_runt + 1'b1;
      if (w_drop && !(&r_drop))
        r_drop <= r_drop + 1'b1;
      if (w_errinc && !(&r_err))
        r_err <= r_err + 1'b1;
      if (r_state == HDR && w_acc)
        for (int i = 0; i < DB; i++)
          if (i < int'(w_n) && int'(r_hcnt) + i < HB)
            r_hdr[8*(int'(r_hcnt)+i) +: 8] <= in_data[8*i +: 8];
    end
  end

  assign out_data  = r_out_data;
  assign out_keep  = r_out_keep;
  assign out_last  = r_out_last;
  assign out_valid = r_out_valid;
  assign hdr_data  = r_hdr;
  assign hdr_valid = r_hdr_valid;
  assign ts_valid  = r_ts_valid;
  assign ts_value  = r_ts;
  assign runt_cnt  = r_runt;
  assign drop_cnt  = r_drop;
  assign err_cnt   = r_err;

endmodule
